// File: rtl/pmem_line_responder.sv
// pmem_line_responder: serves 256-bit cache-line reads/writes from the cache's
// physical-memory port as bursts of narrower beats on the backing memory port.
module pmem_line_responder #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int BEATS     = LINE_BITS / BEAT_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          pmem_address,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic [31:0]          mem_address,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BEAT_BITS-1:0] mem_wdata,
    input  logic [BEAT_BITS-1:0] mem_rdata,
    input  logic                 mem_resp
);

    localparam int BEAT_W  = $clog2(BEATS);
    localparam int OFF_W   = $clog2(LINE_BITS / 8);
    localparam int BYTE_SH = $clog2(BEAT_BITS / 8);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BEAT_W-1:0]      r_beat;
    logic [BEAT_W-1:0]      w_beat_nxt;
    logic [31-OFF_W:0]      r_base_hi;
    logic [LINE_BITS-1:0]   r_line;
    logic [LINE_BITS-1:0]   r_rdata;
    logic                   w_latch_base;
    logic                   w_latch_line;
    logic                   w_capture;
    logic                   w_last;
    logic [OFF_W-1:0]       w_off;
    logic                   w_unused_addr_lo;

    // Byte offset bits of the request address are replaced by the beat offset.
    assign w_unused_addr_lo = &{1'b0, pmem_address[OFF_W-1:0]};
    assign w_last           = (r_beat == BEAT_W'(BEATS - 1));
    assign w_off            = {r_beat, {BYTE_SH{1'b0}}};
    assign pmem_rdata       = r_rdata;

    // Next-state, beat sequencing and bus outputs (Moore outputs from state).
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_latch_base = 1'b0;
        w_latch_line = 1'b0;
        w_capture    = 1'b0;
        pmem_resp    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                // A write wins if the cache ever raises both requests.
                if (pmem_write) begin
                    w_latch_base = 1'b1;
                    w_latch_line = 1'b1;
                    w_beat_nxt   = '0;
                    w_state_nxt  = WR_BURST;
                end else if (pmem_read) begin
                    w_latch_base = 1'b1;
                    w_beat_nxt   = '0;
                    w_state_nxt  = RD_BURST;
                end
            end
            RD_BURST: begin
                mem_read    = 1'b1;
                mem_address = {r_base_hi, w_off};
                if (mem_resp) begin
                    w_capture  = 1'b1;
                    w_beat_nxt = r_beat + BEAT_W'(1);
                    if (w_last) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WR_BURST: begin
                mem_write   = 1'b1;
                mem_address = {r_base_hi, w_off};
                mem_wdata   = r_line[r_beat*BEAT_BITS +: BEAT_BITS];
                if (mem_resp) begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                    if (w_last) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                pmem_resp   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and beat counter; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Request latches, so mid-burst changes on the cache side are ignored.
    always_ff @(posedge clk) begin
        if (w_latch_base) begin
            r_base_hi <= pmem_address[31:OFF_W];
        end
        if (w_latch_line) begin
            r_line <= pmem_wdata;
        end
    end

    // Read line assembly; each accepted read beat fills its own slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rdata[r_beat*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder with hand-computed expectations.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] exp_rdata = '0;

    pmem_line_responder dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete line transaction: cycle 0 in IDLE, beats with 'waits'
    // stall cycles each, the RESP cycle, then the cache drops its request.
    task automatic run_burst(input logic [31:0] addr, input bit rd, input bit wr,
                             input logic [255:0] wline, input logic [63:0] seed,
                             input int waits);
        logic [31:0] base;
        bit          is_wr;
        base  = {addr[31:5], 5'b0};
        is_wr = wr;
        tick();
        pmem_address = addr;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_wdata   = wline;
        mem_resp     = 1'b0;
        #1;
        chk("c0_mem_read", {255'b0, mem_read}, 256'd0);
        chk("c0_mem_write", {255'b0, mem_write}, 256'd0);
        chk("c0_pmem_resp", {255'b0, pmem_resp}, 256'd0);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= waits; w++) begin
                tick();
                mem_resp  = (w == waits);
                mem_rdata = (w == waits) ? seed * 64'(k + 1) : 64'hDEAD_BEEF_DEAD_BEEF;
                if (k == 1) begin
                    pmem_wdata   = ~wline;
                    pmem_address = 32'hFFFF_FFE0;
                end
                #1;
                chk("beat_mem_read", {255'b0, mem_read}, {255'b0, !is_wr});
                chk("beat_mem_write", {255'b0, mem_write}, {255'b0, is_wr});
                chk("beat_mem_address", {224'b0, mem_address}, {224'b0, base + 32'(8 * k)});
                chk("beat_pmem_resp", {255'b0, pmem_resp}, 256'd0);
                if (is_wr) begin
                    chk("beat_mem_wdata", {192'b0, mem_wdata}, {192'b0, wline[64*k +: 64]});
                end
            end
            if (!is_wr) begin
                exp_rdata[64*k +: 64] = seed * 64'(k + 1);
            end
        end
        tick();
        mem_resp = 1'b0;
        #1;
        chk("resp_pmem_resp", {255'b0, pmem_resp}, 256'd1);
        chk("resp_mem_read", {255'b0, mem_read}, 256'd0);
        chk("resp_mem_write", {255'b0, mem_write}, 256'd0);
        chk("resp_pmem_rdata", pmem_rdata, exp_rdata);
        tick();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        #1;
        chk("post_pmem_resp", {255'b0, pmem_resp}, 256'd0);
        chk("post_mem_read", {255'b0, mem_read}, 256'd0);
        chk("post_mem_write", {255'b0, mem_write}, 256'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        tick();
        tick();
        chk("rst_pmem_resp", {255'b0, pmem_resp}, 256'd0);
        chk("rst_mem_read", {255'b0, mem_read}, 256'd0);
        chk("rst_mem_write", {255'b0, mem_write}, 256'd0);
        chk("rst_mem_address", {224'b0, mem_address}, 256'd0);
        chk("rst_mem_wdata", {192'b0, mem_wdata}, 256'd0);
        chk("rst_pmem_rdata", pmem_rdata, 256'd0);
        rst_n = 1'b1;

        // Zero-wait read at 0x1234 -> beats at 0x1220..0x1238.
        run_burst(32'h0000_1234, 1'b1, 1'b0, '0, 64'h1111_1111_1111_1111, 0);
        chk("rd0_line", pmem_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write at 0x40 with beats A, B, C, D; read line must stay intact.
        run_burst(32'h0000_0040, 1'b0, 1'b1,
                  {64'hD, 64'hC, 64'hB, 64'hA}, 64'h0, 0);
        chk("wr_keeps_rdata", pmem_rdata,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Read with 3 wait cycles per beat, distinct data.
        run_burst(32'h0000_3008, 1'b1, 1'b0, '0, 64'h0101_0101_0101_0101, 3);
        chk("rdw_line", pmem_rdata,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});

        // Both requests high: write wins.
        run_burst(32'h0000_0080, 1'b1, 1'b1,
                  {64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F,
                   64'hCAFE_F00D_CAFE_F00D, 64'h8000_0000_0000_0001}, 64'h0, 0);

        // Reset during beat 2 of a read at 0x100.
        tick();
        pmem_address = 32'h0000_0100;
        pmem_read    = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            tick();
            mem_resp  = 1'b1;
            mem_rdata = 64'h7777_0000_0000_0000 + 64'(k);
            #1;
            chk("rst_burst_addr", {224'b0, mem_address}, {224'b0, 32'h100 + 32'(8 * k)});
        end
        tick();
        mem_resp = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_burst_addr2", {224'b0, mem_address}, {224'b0, 32'h0000_0110});
        tick();
        rst_n     = 1'b1;
        pmem_read = 1'b0;
        mem_resp  = 1'b0;
        #1;
        chk("mid_rst_mem_read", {255'b0, mem_read}, 256'd0);
        chk("mid_rst_mem_address", {224'b0, mem_address}, 256'd0);
        chk("mid_rst_pmem_resp", {255'b0, pmem_resp}, 256'd0);
        chk("mid_rst_pmem_rdata", pmem_rdata, 256'd0);
        tick();
        chk("mid_rst_no_resp", {255'b0, pmem_resp}, 256'd0);
        chk("mid_rst_idle", {255'b0, mem_read}, 256'd0);
        exp_rdata = '0;

        // Fresh read after reset, then back-to-back read at a new base.
        run_burst(32'h0000_0200, 1'b1, 1'b0, '0, 64'h0000_0000_0000_0011, 0);
        chk("fresh_line", pmem_rdata,
            {64'h44, 64'h33, 64'h22, 64'h11});
        run_burst(32'h0000_031F, 1'b1, 1'b0, '0, 64'h1000_0000_0000_0000, 0);
        chk("b2b_line", pmem_rdata,
            {64'h4000_0000_0000_0000, 64'h3000_0000_0000_0000,
             64'h2000_0000_0000_0000, 64'h1000_0000_0000_0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
